// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state
// encodings and the default register-index width.
package hazard_ctrl_pkg;

    // Readable view of the 2-bit controller state (matches the debug port).
    typedef enum logic [1:0] {
        HC_RUN        = 2'd0,
        HC_LOAD_STALL = 2'd1,
        HC_MC_BUSY    = 2'd2,
        HC_REDIRECT   = 2'd3
    } hc_state_e;

    // Plain constants used by the FSM so the state register stays a bit vector.
    localparam logic [1:0] ST_RUN        = 2'd0;
    localparam logic [1:0] ST_LOAD_STALL = 2'd1;
    localparam logic [1:0] ST_MC_BUSY    = 2'd2;
    localparam logic [1:0] ST_REDIRECT   = 2'd3;

    localparam int DEF_REG_ADDR_W = 5;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Stall / flush performance counters for the hazard controller.
// Built only when HAZARD_CTRL_PERF_EN is defined. Counters wrap naturally.
module hazard_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [1:0]       inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign inc = {flush_inc, stall_inc};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            // One free-running event counter per tracked condition.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg[gi] <= '0;
                end else if (inc[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: sequences PC write
// enable and hold/flush of IF/ID, ID/EX and EX/MEM from load-use hazards,
// EX-resolved taken branches, multi-cycle EX ops and imem wait states.
// Optional macro HAZARD_CTRL_PERF_EN adds stall/flush perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W    = DEF_REG_ADDR_W,
    parameter int MC_MAX_CYCLES = 40,
    parameter int CNT_W         = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_uses_rs1,
    input  logic                  id_uses_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_mem_read,
    input  logic                  ex_reg_write,
    input  logic                  ex_branch_taken,
    input  logic                  ex_mc_busy,
    input  logic                  mc_done,
    input  logic                  imem_ready,
    output logic                  pc_write_en,
    output logic                  ifid_hold,
    output logic                  ifid_flush,
    output logic                  idex_hold,
    output logic                  idex_flush,
    output logic                  exmem_flush,
    output logic [1:0]            state,
    output logic                  mc_timeout
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
`endif
);

    localparam int WD_W = $clog2(MC_MAX_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MC_MAX_CYCLES - 1);

    logic [1:0]      state_reg, state_next;
    logic [WD_W-1:0] wd_reg, wd_next;
    logic            timeout_reg, timeout_next;
    logic            lu;
    logic            in_run;

    // Load-use: a load in EX writes a register the ID instruction reads.
    assign lu = ex_mem_read & ex_reg_write & (ex_rd != '0) & id_valid &
                ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                 (id_uses_rs2 & (id_rs2 == ex_rd)));

    // Branch and load-use are only meaningful in RUN; LOAD_STALL has a bubble in EX.
    assign in_run = (state_reg == ST_RUN);

    // Next-state, watchdog and stage-control decode.
    always_comb begin
        pc_write_en  = 1'b0;
        ifid_hold    = 1'b0;
        ifid_flush   = 1'b0;
        idex_hold    = 1'b0;
        idex_flush   = 1'b0;
        exmem_flush  = 1'b0;
        state_next   = state_reg;
        wd_next      = wd_reg;
        timeout_next = timeout_reg;

        case (state_reg)
            ST_RUN, ST_LOAD_STALL: begin
                state_next = ST_RUN;
                if (in_run && ex_branch_taken) begin
                    pc_write_en = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    state_next  = ST_REDIRECT;
                end else if (ex_mc_busy && !mc_done) begin
                    ifid_hold   = 1'b1;
                    idex_hold   = 1'b1;
                    exmem_flush = 1'b1;
                    state_next  = ST_MC_BUSY;
                    wd_next     = WD_W'(1);
                end else if (in_run && lu) begin
                    ifid_hold   = 1'b1;
                    idex_flush  = 1'b1;
                    state_next  = ST_LOAD_STALL;
                end else if (!imem_ready) begin
                    ifid_flush  = 1'b1;
                end else begin
                    pc_write_en = 1'b1;
                end
            end
            ST_MC_BUSY: begin
                if (mc_done) begin
                    // Result arrives: resume like RUN, still subject to imem wait.
                    pc_write_en = imem_ready;
                    ifid_flush  = !imem_ready;
                    state_next  = ST_RUN;
                    wd_next     = '0;
                end else begin
                    ifid_hold   = 1'b1;
                    idex_hold   = 1'b1;
                    exmem_flush = 1'b1;
                    wd_next     = wd_reg + 1'b1;
                    if (wd_reg == WD_LAST) begin
                        // Watchdog expired: give up on the unit and unblock the pipe.
                        timeout_next = 1'b1;
                        state_next   = ST_RUN;
                        wd_next      = '0;
                    end
                end
            end
            default: begin // ST_REDIRECT
                if (!imem_ready) begin
                    ifid_flush = 1'b1;
                end else begin
                    pc_write_en = 1'b1;
                    state_next  = ST_RUN;
                end
            end
        endcase

        // A flush always overrides a hold on the same register.
        if (ifid_flush) ifid_hold = 1'b0;
        if (idex_flush) idex_hold = 1'b0;

        // While in reset keep the PC still and the pipeline cleared.
        if (rst) begin
            pc_write_en = 1'b0;
            ifid_hold   = 1'b0;
            idex_hold   = 1'b0;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            exmem_flush = 1'b1;
        end
    end

    // State, watchdog and sticky timeout registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_RUN;
            wd_reg      <= '0;
            timeout_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wd_reg      <= wd_next;
            timeout_reg <= timeout_next;
        end
    end

    assign state      = state_reg;
    assign mc_timeout = timeout_reg;

`ifdef HAZARD_CTRL_PERF_EN
    hazard_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .rst       (rst),
        .stall_inc (!pc_write_en && !rst),
        .flush_inc (ifid_flush && !rst),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );
`endif

endmodule
